// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract engine.
//   state_t          : controller state encoding (IDLE, RUN, DONE), 2 bits
//   SA_DEFAULT_WIDTH : default operand/result width
package serial_add_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/FullAdder_1bit.sv
// One-bit full adder cell, the only arithmetic in the serial engine.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum           : sum bit
//   o_cout          : carry out
module FullAdder_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_sum  = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule : FullAdder_1bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: a single full-adder cell is stepped LSB
// first over WIDTH cycles, with valid/ready handshakes on operands and result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub sampled on accept)
//   a, b, sub            : operands; sub=1 computes a - b
//   out_valid/out_ready  : result handshake
//   sum, cout, overflow  : result, MSB carry (no-borrow for sub), signed overflow
//   busy                 : operation in flight or result pending
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_bit_cnt;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_state == ST_RUN) && (r_bit_cnt == CW'(WIDTH - 1));

    // Single arithmetic cell, fed from the operand LSBs and the carry flop.
    FullAdder_1bit u_fa (
        .i_a    (r_op_a[0]),
        .i_b    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (w_next_state == ST_IDLE);
            out_valid <= (w_next_state == ST_DONE);
            busy      <= (w_next_state != ST_IDLE);
        end
    end

    // Operand/result shift registers, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1: invert b and seed the carry with sub.
            r_op_a    <= a;
            r_op_b    <= b ^ {WIDTH{sub}};
            r_carry   <= sub;
            r_bit_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_op_a    <= r_op_a >> 1;
            r_op_b    <= r_op_b >> 1;
            r_res     <= {w_fa_sum, r_res[WIDTH-1:1]};
            r_carry   <= w_fa_cout;
            r_bit_cnt <= CW'(r_bit_cnt + 1'b1);
            // On the MSB step r_carry is the carry into the MSB.
            if (w_last) begin
                sum      <= {w_fa_sum, r_res[WIDTH-1:1]};
                cout     <= w_fa_cout;
                overflow <= r_carry ^ w_fa_cout;
            end
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH = 8.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int sa, sb, ex, ua, ub;
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        ua = int'(ta);
        ub = int'(tb);
        ex = tsub ? (sa - sb) : (sa + sb);
        es = W'(ex);
        eo = (ex > 127) || (ex < -128);
        ec = tsub ? (ua >= ub) : ((ua + ub) > 255);
    endtask

    // Called at posedge+1 with the block idle; returns at posedge+1, idle again.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                          input int hold, input bit early, input bit pulse);
        logic [W-1:0] es;
        logic         ec, eo;
        int           cnt;
        model(ta, tb, tsub, es, ec, eo);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        sub       = tsub;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        sub      = 1'($urandom_range(0, 1));
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            if (pulse && cnt == 2) begin
                in_valid = 1'b1;
                a        = 8'h11;
                b        = 8'h22;
                sub      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(cnt), 32'(W));
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("overflow", 32'(overflow), 32'(eo));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_sum", 32'(sum), 32'(es));
                chk("hold_cout", 32'(cout), 32'(ec));
                chk("hold_ovf", 32'(overflow), 32'(eo));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 1'b1, 5, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 0, 1'b1, 1'b0);

        // Request pulsed during RUN must be dropped.
        run_op(8'h40, 8'h15, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_second_result", 32'(out_valid), 32'd0);
        end

        // Reset at bit_cnt = 3.
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h22;
        sub      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h03, 8'h04, 1'b0, 0, 1'b0, 1'b0);

        // Reset while a result is pending in DONE.
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        sub      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("done_reached", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("done_abort_valid", 32'(out_valid), 32'd0);
        chk("done_abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("done_abort_no_result", 32'(out_valid), 32'd0);
        end

        // Random operations with mixed backpressure.
        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl
